// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-Lite bus arbiter with lock-aware, burst-aware grant handover on HREADY-high cycles.
// Define AHB_ARB_BURST_HOLD_EN to hold the grant until a fixed-length burst reaches its last beat.
`timescale 1ns/1ps
module ahb_rr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [3:0]         HMASTER,
    output logic               HMASTLOCK
);

    logic [NUM_MST-1:0] hgrant_q, hgrant_d;
    logic [3:0]         gidx_q, gidx_d;
    logic [3:0]         last_q, last_d;
    logic [3:0]         hmaster_q;
    logic               hmastlock_q;

    logic               lock_hold;
    logic               burst_done;
    logic               arb_ok;

    logic [3:0]         start_idx;
    logic [NUM_MST-1:0] req_rot;
    logic               found;
    logic [3:0]         off;
    logic [4:0]         sum;
    logic [3:0]         win_idx;

    assign lock_hold = |(HLOCK & hgrant_q);

`ifdef AHB_ARB_BURST_HOLD_EN
    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;
    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;

    logic [3:0] cnt_q, cnt_d;
    logic       fixed_burst;

    assign fixed_burst = (HBURST != BURST_SINGLE) && (HBURST != BURST_INCR);

    // cnt holds the number of SEQ beats still to come in a fixed-length burst
    always_comb begin
        cnt_d = cnt_q;
        if (HREADY) begin
            case (HTRANS)
                TRANS_NONSEQ: begin
                    case (HBURST)
                        3'd2, 3'd3: cnt_d = 4'd3;
                        3'd4, 3'd5: cnt_d = 4'd7;
                        3'd6, 3'd7: cnt_d = 4'd15;
                        default:    cnt_d = 4'd0;
                    endcase
                end
                TRANS_SEQ: begin
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                end
                TRANS_IDLE: cnt_d = 4'd0;
                default:    cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= 4'd0;
        else          cnt_q <= cnt_d;
    end

    assign burst_done = ((cnt_q == 4'd0) && !((HTRANS == TRANS_NONSEQ) && fixed_burst))
                     || ((cnt_q == 4'd1) && (HTRANS == TRANS_SEQ));
`else
    logic unused_burst_sig;
    assign unused_burst_sig = &{1'b0, HTRANS, HBURST};
    assign burst_done       = 1'b1;
`endif

    assign arb_ok = HREADY & ~lock_hold & burst_done;

    // Rotate requests so bit 0 is the master right after the last winner
    assign start_idx = (last_q == 4'(NUM_MST-1)) ? 4'd0 : last_q + 4'd1;
    assign req_rot   = NUM_MST'({HBUSREQ, HBUSREQ} >> start_idx);

    always_comb begin
        found = 1'b0;
        off   = 4'd0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = 4'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, start_idx} + {1'b0, off};
        if (sum >= 5'(NUM_MST)) win_idx = 4'(sum - 5'(NUM_MST));
        else                    win_idx = 4'(sum);
    end

    always_comb begin
        gidx_d = gidx_q;
        last_d = last_q;
        if (arb_ok) begin
            if (found) begin
                gidx_d = win_idx;
                last_d = win_idx;
            end else begin
                gidx_d = 4'(DEF_MST);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_grant_dec
        assign hgrant_d[gi] = (gidx_d == 4'(gi));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_q    <= NUM_MST'(1) << DEF_MST;
            gidx_q      <= 4'(DEF_MST);
            last_q      <= 4'(DEF_MST);
            hmaster_q   <= 4'(DEF_MST);
            hmastlock_q <= 1'b0;
        end else begin
            hgrant_q <= hgrant_d;
            gidx_q   <= gidx_d;
            last_q   <= last_d;
            if (HREADY) begin
                hmaster_q   <= gidx_q;
                hmastlock_q <= lock_hold;
            end
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: stimulus pushes expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ahb_rr_arbiter;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;
`ifdef AHB_ARB_BURST_HOLD_EN
    localparam int NSEQ = 15;
`else
    localparam int NSEQ = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] busreq = 4'd0;
    logic [3:0] lock = 4'd0;
    logic [1:0] trans = IDLE;
    logic [2:0] burst = SINGLE;
    logic       ready = 1'b1;
    logic [3:0] grant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         tgt;
        logic [3:0] g;
        logic [3:0] m;
        logic       l;
        string      tag;
    } exp_t;

    exp_t sb[$];

    ahb_rr_arbiter #(.NUM_MST(4), .DEF_MST(0)) dut (
        .HCLK(clk),
        .HRESETn(rst_n),
        .HBUSREQ(busreq),
        .HLOCK(lock),
        .HTRANS(trans),
        .HBURST(burst),
        .HREADY(ready),
        .HGRANT(grant),
        .HMASTER(hmaster),
        .HMASTLOCK(hmastlock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic [3:0] eg, input logic [3:0] em, input logic el, input string tag);
        exp_t e;
        e.tgt = cyc + 1;
        e.g   = eg;
        e.m   = em;
        e.l   = el;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; expectation applies to the state after the next edge
    task automatic step(input logic [3:0] rq, input logic [3:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy,
                        input logic [3:0] eg, input logic [3:0] em, input logic el, input string tag);
        busreq = rq;
        lock   = lk;
        trans  = tr;
        burst  = bu;
        ready  = rdy;
        push_exp(eg, em, el, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [3:0] eg, input logic [3:0] em, input logic el);
        n_chk++;
        if (grant !== eg || hmaster !== em || hmastlock !== el) begin
            n_fail++;
            $display("FAIL %s t=%0t: got grant=%b hmaster=%0d hmastlock=%b, expected grant=%b hmaster=%0d hmastlock=%b",
                     tag, $time, grant, hmaster, hmastlock, eg, em, el);
        end else begin
            $display("ok   %s t=%0t: grant=%b hmaster=%0d hmastlock=%b", tag, $time, grant, hmaster, hmastlock);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tgt <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.tgt != cyc || grant !== e.g || hmaster !== e.m || hmastlock !== e.l) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got grant=%b hmaster=%0d hmastlock=%b, expected grant=%b hmaster=%0d hmastlock=%b",
                             e.tag, cyc, grant, hmaster, hmastlock, e.g, e.m, e.l);
                end else begin
                    $display("ok   %s cyc=%0d: grant=%b hmaster=%0d hmastlock=%b", e.tag, cyc, grant, hmaster, hmastlock);
                end
            end
            if (cyc > 0) begin
                n_chk++;
                if (!$onehot(grant)) begin
                    n_fail++;
                    $display("FAIL onehot cyc=%0d: got grant=%b, expected exactly one bit set", cyc, grant);
                end
            end
        end
    end

    int gseq[6] = '{1, 2, 3, 1, 2, 3};
    int mseq[6] = '{0, 1, 2, 3, 1, 2};

    initial begin
        #2 rst_n = 1'b0;
        #1 check_now("reset_async", 4'b0001, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 4'd0, 1'b0, "idle_default");

        for (int i = 0; i < 6; i++)
            step(4'b1110, 4'b0000, NONSEQ, SINGLE, 1'b1, 4'(1 << gseq[i]), 4'(mseq[i]), 1'b0, "rotate");
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 4'd3, 1'b0, "rot_to_default");
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 4'd0, 1'b0, "rot_default_hold");

        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 4'd0, 1'b0, "take_m1");
`ifdef AHB_ARB_BURST_HOLD_EN
        step(4'b0110, 4'b0000, NONSEQ, INCR8, 1'b1, 4'b0010, 4'd1, 1'b0, "incr8_nonseq_hold");
        for (int k = 1; k <= 7; k++)
            step(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, (k == 7) ? 4'b0100 : 4'b0010, 4'd1, 1'b0, "incr8_seq");
`else
        step(4'b0110, 4'b0000, NONSEQ, INCR8, 1'b1, 4'b0100, 4'd1, 1'b0, "incr8_nonseq_early");
`endif
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 4'd2, 1'b0, "m2_owns");

        step(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b1000, 4'd2, 1'b0, "take_m3");
        for (int i = 0; i < 3; i++)
            step(4'b1111, 4'b1000, NONSEQ, SINGLE, 1'b1, 4'b1000, 4'd3, 1'b1, "locked_single");
        step(4'b0111, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 4'd3, 1'b0, "unlock_to_m0");
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 4'd0, 1'b0, "idle_after_lock");

        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 4'd0, 1'b0, "take_m1_stall");
        for (int i = 0; i < 5; i++)
            step(4'b0100, 4'b0000, NONSEQ, INCR4, 1'b0, 4'b0010, 4'd0, 1'b0, "wait_freeze");
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 4'd1, 1'b0, "ready_resume");
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 4'd2, 1'b0, "idle_after_stall");

        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0010, 4'd0, 1'b0, "take_m1_incr16");
        step(4'b0011, 4'b0010, NONSEQ, INCR16, 1'b1, 4'b0010, 4'd1, 1'b1, "incr16_nonseq");
        for (int k = 1; k <= 5; k++)
            step(4'b0011, 4'b0010, SEQ, INCR16, 1'b1, 4'b0010, 4'd1, 1'b1, "incr16_seq");

        busreq = 4'b0011;
        lock   = 4'b0010;
        trans  = SEQ;
        burst  = INCR16;
        ready  = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_now("reset_mid_burst", 4'b0001, 4'd0, 1'b0);
        push_exp(4'b0001, 4'd0, 1'b0, "reset_held");
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(4'b0001, 4'b0000, NONSEQ, INCR16, 1'b1, 4'b0001, 4'd0, 1'b0, "incr16_reload");
        for (int k = 1; k <= NSEQ; k++)
            step(4'b0011, 4'b0000, SEQ, INCR16, 1'b1, (k == NSEQ) ? 4'b0010 : 4'b0001, 4'd0, 1'b0, "reload_seq");

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
